// File: rtl/int_div_pkg.sv
// Shared types and sizing helpers for the sequential integer divider.
package int_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Counter must hold WIDTH-1 and still have headroom for the increment.
    function automatic int unsigned cnt_width(input int unsigned width);
        return 32'($clog2(width)) + 32'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, q_i[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_i};
        qbit_o  = ~diff[WIDTH];
        rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_o     = {q_i[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/int_divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake,
// optional signed mode and divide-by-zero reporting.
module int_divider_seq
    import int_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   quo_w_q, quo_w_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rmdr_q, rmdr_d;
    logic               dbz_q, dbz_d;

    logic               sgn_c;
    logic               dvd_neg_c, dvs_neg_c;
    logic [WIDTH-1:0]   dvd_mag_c, dvs_mag_c;
    logic [WIDTH-1:0]   step_rem, step_q;
    logic               step_qbit;
    logic               accept_c;

    assign accept_c = start & ~busy_q;

    // Operand signs and magnitudes; SIGNED_EN=0 folds all of this away.
    always_comb begin
        sgn_c     = signed_op & SIGNED_EN;
        dvd_neg_c = sgn_c & dividend[WIDTH-1];
        dvs_neg_c = sgn_c & divisor[WIDTH-1];
        dvd_mag_c = dvd_neg_c ? -dividend : dividend;
        dvs_mag_c = dvs_neg_c ? -divisor  : divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (acc_q),
        .q_i    (quo_w_q),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .q_o    (step_q),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-state; done defaults low so it only pulses.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quo_w_d = quo_w_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    quo_w_d = dvd_mag_c;
                    dvs_d   = dvs_mag_c;
                    dvd_d   = dividend;
                    negq_d  = dvd_neg_c ^ dvs_neg_c;
                    negr_d  = dvd_neg_c;
                    zero_d  = (divisor == '0);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d   = step_rem;
                quo_w_d = step_q | {{(WIDTH-1){1'b0}}, step_qbit};
                cnt_d   = cnt_q + CNT_W'(1);
            end
            FIX: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                dbz_d  = zero_q;
                if (zero_q) begin
                    quot_d = '1;
                    rmdr_d = dvd_q;
                end else begin
                    quot_d = negq_q ? -quo_w_q : quo_w_q;
                    rmdr_d = negr_q ? -acc_q   : acc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_w_q <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            quo_w_q <= quo_w_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmdr_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_int_divider_seq.sv
// Directed bench for int_divider_seq: 32-bit signed instance plus an 8-bit unsigned-only instance.
module tb_int_divider_seq;

    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        s8_start = 1'b0;
    logic        s8_signed = 1'b0;
    logic [7:0]  s8_dvd = '0;
    logic [7:0]  s8_dvs = '0;
    logic        s8_busy, s8_done, s8_dbz;
    logic [7:0]  s8_q, s8_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_divider_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    int_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .signed_op(s8_signed),
        .dividend(s8_dvd), .divisor(s8_dvs), .busy(s8_busy), .done(s8_done),
        .quotient(s8_q), .remainder(s8_r), .div_by_zero(s8_dbz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from mid-cycle, scramble operands after the start edge, and
    // optionally pulse a competing start glitch_at edges later. Returns one edge past done.
    task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int glitch_at);
        int lat;
        lat = 0;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = ~a;
        divisor   = b + 32'd3;
        signed_op = ~s;
        chk({tag, " busy_rise"}, 64'(busy), 64'(1'b1));
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == glitch_at) begin
                start     = 1'b1;
                dividend  = 32'd77;
                divisor   = 32'd5;
                signed_op = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(W + 1));
        chk({tag, " quotient"}, 64'(quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(remainder), 64'(er));
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(ez));
        chk({tag, " busy_fall"}, 64'(busy), 64'(1'b0));
    endtask

    initial begin
        int lat8;
        int done_seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(1'b0));
        chk("reset done", 64'(done), 64'(1'b0));
        chk("reset quotient", 64'(quotient), 64'(32'd0));
        chk("reset remainder", 64'(remainder), 64'(32'd0));
        chk("reset dbz", 64'(div_by_zero), 64'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Each op after the first starts while done is high: back-to-back acceptance.
        do_op("u13_3",    1'b0, 32'd13,        32'd3,         32'd4,         32'd1,         1'b0, 0);
        do_op("s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 0);
        do_op("s7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 0);
        do_op("u5_0",     1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 0);
        do_op("s-5_0",    1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 0);
        do_op("smin_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 0);
        do_op("umin_m1",  1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 0);
        do_op("s-100_-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 0);
        do_op("glitch",   1'b0, 32'd1000,      32'd9,         32'd111,       32'd1,         1'b0, 5);

        @(posedge clk); #1;
        chk("pulse done_low", 64'(done), 64'(1'b0));
        chk("pulse busy_low", 64'(busy), 64'(1'b0));
        chk("pulse q_held", 64'(quotient), 64'(32'd111));
        chk("pulse r_held", 64'(remainder), 64'(32'd1));

        // Asynchronous abort in the middle of RUN.
        signed_op = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'(1'b0));
        chk("abort quotient", 64'(quotient), 64'(32'd0));
        chk("abort remainder", 64'(remainder), 64'(32'd0));
        chk("abort done", 64'(done), 64'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        chk("abort no_done", 64'(done_seen), 64'(0));
        chk("abort idle", 64'(busy), 64'(1'b0));

        // 8-bit unsigned-only instance: signed_op must be ignored (0xC8 would be -56 signed).
        s8_signed = 1'b1;
        s8_dvd    = 8'd200;
        s8_dvs    = 8'd7;
        s8_start  = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        s8_dvd   = 8'd1;
        lat8 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (s8_done === 1'b1) begin
                lat8 = k;
                break;
            end
        end
        chk("w8 latency", 64'(lat8), 64'(9));
        chk("w8 quotient", 64'(s8_q), 64'(8'd28));
        chk("w8 remainder", 64'(s8_r), 64'(8'd4));
        chk("w8 dbz", 64'(s8_dbz), 64'(1'b0));
        chk("w8 busy_fall", 64'(s8_busy), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
